// File: rtl/sap_control_sequencer.sv
// Six-state ring-counter control sequencer for the SAP-style 8-bit computer.
// Optional single-step front end is enabled with the SEQ_SINGLE_STEP_EN macro.
module sap_control_sequencer #(
    parameter logic [3:0] LDA_OP = 4'h0,
    parameter logic [3:0] ADD_OP = 4'h1,
    parameter logic [3:0] SUB_OP = 4'h2,
    parameter logic [3:0] OUT_OP = 4'hE,
    parameter logic [3:0] HLT_OP = 4'hF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] opcode,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic       step_mode,
    input  logic       step,
`endif
    output logic [5:0] t_state,
    output logic       running,
    output logic       halted,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       mar_load,
    output logic       ram_out,
    output logic       ir_load,
    output logic       ir_out,
    output logic       a_load,
    output logic       a_out,
    output logic       b_load,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       out_load
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_e;

    tstate_e t_state_q, t_state_d;
    logic    running_q, running_d;
    logic    halted_q, halted_d;
    logic    stop_pend_q, stop_pend_d;
    logic    adv_en;

`ifdef SEQ_SINGLE_STEP_EN
    logic [1:0] step_sync_q;
    logic       step_prev_q;
    logic       step_rise;

    // The step button is asynchronous, so it is synchronised before edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_sync_q <= 2'b00;
            step_prev_q <= 1'b0;
        end else begin
            step_sync_q <= {step_sync_q[0], step};
            step_prev_q <= step_sync_q[1];
        end
    end

    assign step_rise = step_sync_q[1] & ~step_prev_q;
    assign adv_en    = step_mode ? step_rise : tick;
`else
    assign adv_en = tick;
`endif

    always_comb begin
        t_state_d   = t_state_q;
        running_d   = running_q;
        halted_d    = halted_q;
        stop_pend_d = stop_pend_q;

        if (adv_en && running_q) begin
            if (t_state_q == T4 && opcode == HLT_OP) begin
                t_state_d = T1;
                running_d = 1'b0;
                halted_d  = 1'b1;
            end else if (t_state_q == T6 && stop_pend_q) begin
                t_state_d   = T1;
                running_d   = 1'b0;
                stop_pend_d = 1'b0;
            end else begin
                t_state_d = tstate_e'({t_state_q[4:0], t_state_q[5]});
            end
        end

        // Run control is sampled every clock, not only on ticks; start beats stop.
        if (start) begin
            running_d   = 1'b1;
            halted_d    = 1'b0;
            stop_pend_d = 1'b0;
        end else if (stop) begin
            stop_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t_state_q   <= T1;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            t_state_q   <= t_state_d;
            running_q   <= running_d;
            halted_q    <= halted_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    assign t_state = t_state_q;
    assign running = running_q;
    assign halted  = halted_q;

    always_comb begin
        pc_out   = 1'b0;
        pc_inc   = 1'b0;
        mar_load = 1'b0;
        ram_out  = 1'b0;
        ir_load  = 1'b0;
        ir_out   = 1'b0;
        a_load   = 1'b0;
        a_out    = 1'b0;
        b_load   = 1'b0;
        alu_out  = 1'b0;
        alu_sub  = 1'b0;
        out_load = 1'b0;

        if (running_q) begin
            unique case (t_state_q)
                T1: begin
                    pc_out   = 1'b1;
                    mar_load = 1'b1;
                end
                T2: pc_inc = 1'b1;
                T3: begin
                    ram_out = 1'b1;
                    ir_load = 1'b1;
                end
                T4: begin
                    if (opcode == LDA_OP || opcode == ADD_OP || opcode == SUB_OP) begin
                        ir_out   = 1'b1;
                        mar_load = 1'b1;
                    end else if (opcode == OUT_OP) begin
                        a_out    = 1'b1;
                        out_load = 1'b1;
                    end
                end
                T5: begin
                    if (opcode == LDA_OP) begin
                        ram_out = 1'b1;
                        a_load  = 1'b1;
                    end else if (opcode == ADD_OP || opcode == SUB_OP) begin
                        ram_out = 1'b1;
                        b_load  = 1'b1;
                    end
                end
                T6: begin
                    if (opcode == ADD_OP || opcode == SUB_OP) begin
                        alu_out = 1'b1;
                        a_load  = 1'b1;
                        alu_sub = (opcode == SUB_OP);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Randomised bench for sap_control_sequencer against an instruction-level reference model.
// With SEQ_SINGLE_STEP_EN defined it also exercises the single-step front end.
module tb_sap_control_sequencer;

    localparam logic [3:0] LDA = 4'h0, ADD = 4'h1, SUB = 4'h2, OUTI = 4'hE, HLT = 4'hF;

    logic       clk = 1'b0;
    logic       reset, tick, start, stop;
    logic [3:0] opcode;
`ifdef SEQ_SINGLE_STEP_EN
    logic       step_mode, step;
`endif
    logic [5:0] t_state;
    logic       running, halted;
    logic       pc_out, pc_inc, mar_load, ram_out, ir_load, ir_out;
    logic       a_load, a_out, b_load, alu_out, alu_sub, out_load;

    always #5 clk = ~clk;

    sap_control_sequencer dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop), .opcode(opcode),
`ifdef SEQ_SINGLE_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .t_state(t_state), .running(running), .halted(halted),
        .pc_out(pc_out), .pc_inc(pc_inc), .mar_load(mar_load), .ram_out(ram_out),
        .ir_load(ir_load), .ir_out(ir_out), .a_load(a_load), .a_out(a_out),
        .b_load(b_load), .alu_out(alu_out), .alu_sub(alu_sub), .out_load(out_load)
    );

    wire [11:0] ctrlObs = {pc_out, pc_inc, mar_load, ram_out, ir_load, ir_out,
                           a_load, a_out, b_load, alu_out, alu_sub, out_load};

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: instruction step index 0..5 plus run/halt/stop-pending flags.
    int stepIdx;
    bit mRun, mHalt, mPend;

    task automatic checkOutput(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] expCtrl(input int s, input logic [3:0] op, input bit run);
        logic [11:0] c;
        c = '0;
        if (run) begin
            case (s)
                0: c = 12'b1010_0000_0000;
                1: c = 12'b0100_0000_0000;
                2: c = 12'b0001_1000_0000;
                3: if (op == LDA || op == ADD || op == SUB) c = 12'b0010_0100_0000;
                   else if (op == OUTI) c = 12'b0000_0001_0001;
                4: if (op == LDA) c = 12'b0001_0010_0000;
                   else if (op == ADD || op == SUB) c = 12'b0001_0000_1000;
                5: if (op == ADD) c = 12'b0000_0010_0100;
                   else if (op == SUB) c = 12'b0000_0010_0110;
                default: c = '0;
            endcase
        end
        return c;
    endfunction

    task automatic modelReset();
        stepIdx = 0;
        mRun    = 0;
        mHalt   = 0;
        mPend   = 0;
    endtask

    task automatic modelEdge(input bit tk, input bit st, input bit sp, input logic [3:0] op);
        if (tk && mRun) begin
            if (stepIdx == 3 && op == HLT) begin
                stepIdx = 0; mRun = 0; mHalt = 1;
            end else if (stepIdx == 5 && mPend) begin
                stepIdx = 0; mRun = 0; mPend = 0;
            end else begin
                stepIdx = (stepIdx + 1) % 6;
            end
        end
        if (st) begin
            mRun = 1; mHalt = 0; mPend = 0;
        end else if (sp) begin
            mPend = 1;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".tstate"}, {6'd0, t_state}, 12'(6'b1 << stepIdx));
        checkOutput({tag, ".running"}, {11'd0, running}, {11'd0, mRun});
        checkOutput({tag, ".halted"}, {11'd0, halted}, {11'd0, mHalt});
        checkOutput({tag, ".ctrl"}, ctrlObs, expCtrl(stepIdx, opcode, mRun));
    endtask

    // One clock of stimulus; rst asserts reset asynchronously mid-cycle and releases it before the edge.
    task automatic applyStimulus(input bit tk, input bit st, input bit sp, input logic [3:0] op, input bit rst);
        @(negedge clk);
        tick = tk; start = st; stop = sp; opcode = op;
        if (rst) begin
            reset = 1'b0;
            #1;
            modelReset();
            checkAll("reset");
            #1 reset = 1'b1;
        end else begin
            #1;
            checkAll("cycle");
        end
        @(posedge clk);
        modelEdge(tk, st, sp, op);
    endtask

    initial begin
        reset = 1'b0; tick = 0; start = 0; stop = 0; opcode = LDA;
`ifdef SEQ_SINGLE_STEP_EN
        step_mode = 0; step = 0;
`endif
        modelReset();
        #12;
        applyStimulus(0, 0, 0, LDA, 1);

        // LDA walk-through, then reset while in T3, then idle
        applyStimulus(0, 1, 0, LDA, 0);
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, LDA, 0);
        applyStimulus(1, 0, 0, LDA, 0);
        applyStimulus(1, 0, 0, LDA, 0);
        applyStimulus(1, 0, 0, LDA, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, LDA, 0);

        // ADD, SUB, then HLT with extra ticks and restart
        applyStimulus(0, 1, 0, ADD, 0);
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, ADD, 0);
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, SUB, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, HLT, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, HLT, 0);
        applyStimulus(0, 1, 0, LDA, 0);

        // Stop in T2, instruction completes; start+stop together; tick held low in T3
        applyStimulus(1, 0, 0, OUTI, 0);
        applyStimulus(1, 0, 1, OUTI, 0);
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, OUTI, 0);
        applyStimulus(0, 1, 1, ADD, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, ADD, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, ADD, 0);

        for (int i = 0; i < 3000; i++) begin
            logic [3:0] op;
            int sel;
            sel = $urandom_range(0, 7);
            case (sel)
                0, 1: op = LDA;
                2:    op = ADD;
                3:    op = SUB;
                4:    op = OUTI;
                5:    op = ($urandom_range(0, 3) == 0) ? HLT : ADD;
                default: op = 4'($urandom_range(0, 15));
            endcase
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                          $urandom_range(0, 29) == 0, op, $urandom_range(0, 149) == 0);
        end

`ifdef SEQ_SINGLE_STEP_EN
        applyStimulus(0, 0, 0, LDA, 1);
        applyStimulus(0, 1, 0, LDA, 0);
        @(negedge clk);
        step_mode = 1; tick = 1; start = 0; stop = 0; opcode = LDA;
        for (int i = 0; i < 6; i++) @(negedge clk);
        #1 checkOutput("step.idle", {6'd0, t_state}, 12'h001);
        for (int p = 0; p < 3; p++) begin
            @(negedge clk) step = 1;
            for (int i = 0; i < 2; i++) @(negedge clk);
            @(negedge clk) step = 0;
            for (int i = 0; i < 4; i++) @(negedge clk);
            #1 checkOutput("step.pulse", {6'd0, t_state}, 12'(6'b1 << (p + 1)));
        end
        checkOutput("step.running", {11'd0, running}, 12'h001);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/sap_control_sequencer.md
Name: sap_control_sequencer

Overview:
- Ring-counter control sequencer for the 8-bit SAP-style computer.
- Steps through six T-states per instruction: fetch (T1–T3), then execute (T4–T6) decoded from the IR opcode nibble.
- Drives one active-high control line per datapath element: program counter, MAR, RAM, IR, A/B registers, ALU and output register.
- Owns run/halt state, so start, stop and HLT all go through this block instead of the program counter's own enable.

Parameters:
- LDA_OP, 4'h0, opcode for load accumulator
- ADD_OP, 4'h1, opcode for add
- SUB_OP, 4'h2, opcode for subtract
- OUT_OP, 4'hE, opcode for output
- HLT_OP, 4'hF, opcode for halt

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-low reset
- tick  input  1  clock-enable from slow-clock divider; all state advances only on clk edges where tick=1
- start  input  1  sets run state
- stop  input  1  requests stop at the next instruction boundary
- opcode  input  4  IR upper nibble; sampled/decoded in T4–T6 only
- t_state  output  6  one-hot T-state, bit0=T1 … bit5=T6
- running  output  1  sequencer running
- halted  output  1  stopped by HLT
- pc_out, pc_inc, mar_load, ram_out, ir_load, ir_out, a_load, a_out, b_load, alu_out, alu_sub, out_load  output  1 each  datapath controls, active-high

Behaviour:
- Reset asserted (reset=0), regardless of clk or state:
  - t_state=6'b000001; running=0; halted=0; stop_pend=0.
  - All controls 0.
- Control outputs:
  - Combinational decode of t_state and opcode, ANDed with running.
  - Datapath samples them on the clk edge where tick=1.
- Decode, per T-state (asserted controls):
  - T1: pc_out, mar_load.
  - T2: pc_inc.
  - T3: ram_out, ir_load.
  - T4: LDA/ADD/SUB → ir_out, mar_load. OUT → a_out, out_load. HLT → none. Other opcodes → none (NOP).
  - T5: LDA → ram_out, a_load. ADD/SUB → ram_out, b_load. Others → none.
  - T6: ADD → alu_out, a_load. SUB → alu_out, alu_sub, a_load. Others → none.
- Advance: on clk with tick=1 and running=1, t_state rotates left; T6 wraps to T1. With tick=0 or running=0, t_state holds.
- Run flop (evaluated every clk, independent of tick):
  - start=1 → running=1, halted=0, stop_pend=0.
  - Else stop=1 → stop_pend=1.
  - start wins over a simultaneous stop.
- Stop request:
  - stop_pend takes effect only at the T6→T1 tick: t_state→T1, running=0, stop_pend=0.
  - The current instruction always completes.
  - stop while already stopped has no effect beyond setting stop_pend, which the next start clears.
- HLT:
  - At the tick leaving T4 with opcode=HLT_OP: running=0, halted=1, t_state→T1 (skips T5/T6).
  - PC has already been incremented, so a later start fetches the instruction after HLT.
- Start while running: no effect on t_state. Does clear stop_pend.
- Reset mid-instruction: immediate return to T1 with controls low. No partial-instruction completion.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds inputs step_mode (1) and step (1).
  - step passes through a 2-flop synchronizer plus rising-edge detect. Synchronizer flops reset to 0.
  - When step_mode=1, the advance condition is step_rise instead of tick. Run/stop/HLT rules are unchanged.
  - One step pulse gives exactly one T-state advance.
- Undefined: ports absent; behaviour identical to step_mode=0.

Test Plan:
- Start, then drive reset=0 while in T3 → same cycle t_state=000001, running=0, all controls 0. Release reset → state holds until start.
- start, opcode=LDA_OP, 6 ticks → T1 {pc_out,mar_load}, T2 {pc_inc}, T3 {ram_out,ir_load}, T4 {ir_out,mar_load}, T5 {ram_out,a_load}, T6 {} → back to T1, running=1.
- opcode=SUB_OP at T6 → alu_out=alu_sub=a_load=1, others 0. opcode=ADD_OP at T6 → alu_out=a_load=1, alu_sub=0.
- opcode=HLT_OP, tick out of T4 → running=0, halted=1, t_state=000001. 5 more ticks → no change. start → running=1, halted=0.
- stop pulsed in T2 → T3–T6 proceed normally; running falls at the T6→T1 tick. start and stop in the same cycle → running stays 1, stop_pend=0.
- tick held 0 for 10 clk in T3 → t_state and controls stable. With SEQ_SINGLE_STEP_EN, step_mode=1, 3 step pulses → exactly 3 advances; free-running tick ignored.
